bk_save_streamer: RTL and testbench

//  Upload-direction counterpart of the cart download path: streams cartridge backup RAM out to the

---
 rtl/bk_pkg.sv | 29 ++
 rtl/bk_save_streamer_if.sv | 21 ++
 rtl/bk_save_streamer.sv | 181 ++++++++++++++++++
 tb/tb_bk_save_streamer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared types for the backup-RAM save streamer: FSM states, sector geometry and
// the cart-header RAM size to sector count mapping.
package bk_pkg;

    localparam int SECTOR_WORDS  = 256;
    localparam int SECTOR_ADDR_W = $clog2(SECTOR_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK_WAIT,
        ST_XFER,
        ST_NEXT,
        ST_FINISH
    } bk_state_t;

    // Header code 0x149 -> number of 512-byte sectors holding the backup RAM.
    function automatic logic [8:0] ram_size_to_nsec(input logic [7:0] ram_size);
        case (ram_size)
            8'h01:   return 9'd4;
            8'h02:   return 9'd16;
            8'h03:   return 9'd64;
            8'h04:   return 9'd256;
            8'h05:   return 9'd128;
            default: return 9'd0;
        endcase
    endfunction

endpackage

// File: rtl/bk_save_streamer_if.sv
// SD sector-write bundle between the save streamer (master) and hps_io (slave).
interface bk_save_streamer_if;
    import bk_pkg::*;

    logic [31:0]              sd_lba;
    logic                     sd_wr;
    logic                     sd_ack;
    logic [SECTOR_ADDR_W-1:0] sd_buff_addr;
    logic [15:0]              sd_buff_din;

    modport master (
        output sd_lba, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr
    );

    modport slave (
        input  sd_lba, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr
    );

endinterface

// File: rtl/bk_save_streamer.sv
// Streams cartridge backup RAM to the mounted save image one 512-byte sector at a time.
// Optional OSD-close autosave is compiled in when BK_AUTOSAVE_EN is defined.
module bk_save_streamer
    import bk_pkg::*;
#(
    parameter int          TIMEOUT_W = 24,
    parameter logic [31:0] LBA_BASE  = 32'd0
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   save_req,
    input  logic                   osd_status,
    input  logic                   autosave_on,
    input  logic [7:0]             ram_size,
    input  logic                   ram_wr,
    input  logic                   img_mounted,
    input  logic                   img_readonly,
    bk_save_streamer_if.master     sd,
    output logic [15:0]            bram_addr,
    input  logic [15:0]            bram_q,
    output logic                   busy,
    output logic                   dirty,
    output logic                   done,
    output logic                   err
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    bk_state_t            state_reg, state_next;
    logic [8:0]           sector_reg, sector_next;
    logic [TIMEOUT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]          sd_lba_reg, sd_lba_next;
    logic                 sd_wr_reg, sd_wr_next;
    logic                 busy_reg, busy_next;
    logic                 dirty_reg, dirty_next;
    logic                 done_reg, done_next;
    logic                 err_reg, err_next;
    logic                 mounted_reg;

    logic [8:0]           nsec;
    logic [8:0]           sector_inc;
    logic                 savable;
    logic                 autosave_trig;
    logic                 start_req;

    assign nsec       = ram_size_to_nsec(ram_size);
    assign sector_inc = sector_reg + 9'd1;
    assign savable    = mounted_reg & ~img_readonly & (nsec != 9'd0);

`ifdef BK_AUTOSAVE_EN
    logic osd_prev_reg;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            osd_prev_reg <= 1'b0;
        end else begin
            osd_prev_reg <= osd_status;
        end
    end

    // Closing the OSD (1->0) flushes pending writes when the option is on.
    assign autosave_trig = osd_prev_reg & ~osd_status & autosave_on & dirty_reg & savable;
`else
    logic unused_autosave;
    assign unused_autosave = &{1'b0, osd_status, autosave_on};
    assign autosave_trig   = 1'b0;
`endif

    assign start_req = save_req | autosave_trig;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            sector_reg  <= 9'd0;
            cnt_reg     <= '0;
            sd_lba_reg  <= 32'd0;
            sd_wr_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            dirty_reg   <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            mounted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sector_reg  <= sector_next;
            cnt_reg     <= cnt_next;
            sd_lba_reg  <= sd_lba_next;
            sd_wr_reg   <= sd_wr_next;
            busy_reg    <= busy_next;
            dirty_reg   <= dirty_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            mounted_reg <= mounted_reg | img_mounted;
        end
    end

    always_comb begin
        state_next  = state_reg;
        sector_next = sector_reg;
        cnt_next    = cnt_reg;
        sd_lba_next = sd_lba_reg;
        sd_wr_next  = sd_wr_reg;
        busy_next   = busy_reg;
        dirty_next  = dirty_reg | ram_wr;
        done_next   = 1'b0;
        err_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start_req) begin
                    if (savable) begin
                        state_next  = ST_REQ;
                        sector_next = 9'd0;
                        busy_next   = 1'b1;
                        dirty_next  = ram_wr;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            ST_REQ: begin
                sd_lba_next = LBA_BASE + {23'd0, sector_reg};
                sd_wr_next  = 1'b1;
                cnt_next    = '0;
                state_next  = ST_ACK_WAIT;
            end

            ST_ACK_WAIT: begin
                if (sd.sd_ack) begin
                    sd_wr_next = 1'b0;
                    state_next = ST_XFER;
                end else if (cnt_reg == CNT_LAST) begin
                    // Host never answered: give up and keep the image marked unsaved.
                    cnt_next   = CNT_MAX;
                    sd_wr_next = 1'b0;
                    err_next   = 1'b1;
                    busy_next  = 1'b0;
                    dirty_next = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_XFER: begin
                if (!sd.sd_ack) begin
                    state_next = ST_NEXT;
                end
            end

            ST_NEXT: begin
                sector_next = sector_inc;
                // >= also terminates cleanly if ram_size shrinks mid-save.
                state_next  = (sector_inc >= nsec) ? ST_FINISH : ST_REQ;
            end

            ST_FINISH: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // hps_io samples sd_buff_din one cycle after presenting sd_buff_addr, matching BRAM latency.
    assign bram_addr      = {sector_reg[7:0], sd.sd_buff_addr};
    assign sd.sd_buff_din = bram_q;
    assign sd.sd_lba      = sd_lba_reg;
    assign sd.sd_wr       = sd_wr_reg;
    assign busy           = busy_reg;
    assign dirty          = dirty_reg;
    assign done           = done_reg;
    assign err            = err_reg;

endmodule

// File: tb/tb_bk_save_streamer.sv
// Directed bench for bk_save_streamer: acts as hps_io and backup BRAM, checks against a sector model.
`timescale 1ns/1ps
module tb_bk_save_streamer;

    localparam int          TW   = 4;
    localparam logic [31:0] BASE = 32'hFFFF_FFF8;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        save_req = 1'b0;
    logic        osd_status = 1'b0;
    logic        autosave_on = 1'b0;
    logic [7:0]  ram_size = 8'd0;
    logic        ram_wr = 1'b0;
    logic        img_mounted = 1'b0;
    logic        img_readonly = 1'b0;
    logic [15:0] bram_addr;
    logic [15:0] bram_q = 16'd0;
    logic        busy, dirty, done, err;

    bk_save_streamer_if sd();

    bk_save_streamer #(.TIMEOUT_W(TW), .LBA_BASE(BASE)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .save_req     (save_req),
        .osd_status   (osd_status),
        .autosave_on  (autosave_on),
        .ram_size     (ram_size),
        .ram_wr       (ram_wr),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .sd           (sd),
        .bram_addr    (bram_addr),
        .bram_q       (bram_q),
        .busy         (busy),
        .dirty        (dirty),
        .done         (done),
        .err          (err)
    );

    always #5 clk_sys = ~clk_sys;

    logic [15:0] mem [0:65535];
    always @(posedge clk_sys) bram_q <= mem[bram_addr];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int wr_rises = 0;
    logic wr_prev = 1'b0, done_prev = 1'b0, err_prev = 1'b0;
    logic [15:0] word_0305 = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Sector count = backup RAM bytes / 512, RAM bytes from the header size code.
    function automatic int model_nsec(input logic [7:0] code);
        int kbytes;
        case (code)
            8'h01:   kbytes = 2;
            8'h02:   kbytes = 8;
            8'h03:   kbytes = 32;
            8'h04:   kbytes = 128;
            8'h05:   kbytes = 64;
            default: kbytes = 0;
        endcase
        return kbytes * 1024 / 512;
    endfunction

    // Per-cycle invariants on the DUT outputs.
    always @(negedge clk_sys) begin
        check("wr_implies_busy", {31'd0, (!sd.sd_wr) || busy}, 32'd1);
        check("done_one_cycle", {31'd0, !(done && done_prev)}, 32'd1);
        check("err_one_cycle", {31'd0, !(err && err_prev)}, 32'd1);
        if (done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
        if (sd.sd_wr && !wr_prev) wr_rises <= wr_rises + 1;
        wr_prev   <= sd.sd_wr;
        done_prev <= done;
        err_prev  <= err;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic pulse_save();
        save_req = 1'b1;
        @(negedge clk_sys);
        save_req = 1'b0;
    endtask

    task automatic pulse_ram_wr();
        ram_wr = 1'b1;
        @(negedge clk_sys);
        ram_wr = 1'b0;
    endtask

    // Plays hps_io for nsec sectors; optional ram_wr / save_req pulses inside one sector.
    task automatic serve(input int nsec, input int wr_sec, input int req_sec);
        int n;
        logic [15:0] ea;
        for (int s = 0; s < nsec; s++) begin
            n = 0;
            while (!sd.sd_wr && n < 50) begin
                @(negedge clk_sys);
                n++;
            end
            if (!sd.sd_wr) begin
                check("sd_wr_wait_timeout", 32'd0, 32'd1);
                return;
            end
            check("sd_lba", sd.sd_lba, BASE + 32'(s));
            repeat (s % 3) begin
                @(negedge clk_sys);
                check("sd_wr_held", {31'd0, sd.sd_wr}, 32'd1);
            end
            for (int a = 0; a <= 256; a++) begin
                if (a > 0) begin
                    ea = 16'(s * 256 + a - 1);
                    check("sd_buff_din", {16'd0, sd.sd_buff_din}, {16'd0, mem[ea]});
                    if (s == 3 && a == 6) word_0305 = sd.sd_buff_din;
                end
                if (a == 1) check("sd_wr_dropped_on_ack", {31'd0, sd.sd_wr}, 32'd0);
                if (a < 256) sd.sd_buff_addr = 8'(a);
                sd.sd_ack = (a < 256);
                ram_wr    = (s == wr_sec) && (a == 10);
                save_req  = (s == req_sec) && (a == 20);
                @(negedge clk_sys);
            end
            sd.sd_buff_addr = 8'd0;
            $display("sector %0d lba=0x%08h served", s, BASE + 32'(s));
        end
    endtask

    task automatic wait_done(input int base_done);
        int n;
        n = 0;
        while (done_cnt == base_done && n < 40) begin
            @(negedge clk_sys);
            n++;
        end
        check("done_seen", {31'd0, done_cnt > base_done}, 32'd1);
        @(negedge clk_sys);
    endtask

    task automatic run_save(input logic [7:0] code, input int wr_sec, input int req_sec,
                            input logic exp_dirty, input string tag);
        int d0, e0, r0, ns;
        d0 = done_cnt; e0 = err_cnt; r0 = wr_rises;
        ns = model_nsec(code);
        ram_size = code;
        pulse_save();
        serve(ns, wr_sec, req_sec);
        wait_done(d0);
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_err_count"}, 32'(err_cnt - e0), 32'd0);
        check({tag, "_wr_count"}, 32'(wr_rises - r0), 32'(ns));
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_dirty"}, {31'd0, dirty}, {31'd0, exp_dirty});
        r0 = wr_rises;
        tick(20);
        check({tag, "_no_requeue"}, 32'(wr_rises - r0), 32'd0);
        $display("save %s: %0d sectors, dirty=%0d", tag, ns, dirty);
    endtask

    task automatic expect_reject(input string tag);
        int e0, r0;
        e0 = err_cnt; r0 = wr_rises;
        pulse_save();
        tick(3);
        check({tag, "_err_pulse"}, 32'(err_cnt - e0), 32'd1);
        check({tag, "_no_wr"}, 32'(wr_rises - r0), 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        $display("reject %s: err pulses=%0d", tag, err_cnt - e0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d0, e0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503) ^ 16'h5A5A;
        mem[16'h0305] = 16'h1234;
        sd.sd_ack = 1'b0;
        sd.sd_buff_addr = 8'd0;

        tick(3);
        check("rst_sd_wr", {31'd0, sd.sd_wr}, 32'd0);
        check("rst_sd_lba", sd.sd_lba, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_dirty", {31'd0, dirty}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        reset_n = 1'b1;
        tick(2);

        ram_size = 8'h02;
        expect_reject("unmounted");
        img_mounted = 1'b1; tick(1); img_mounted = 1'b0;
        ram_size = 8'h00;
        expect_reject("size0");
        ram_size = 8'h02; img_readonly = 1'b1;
        expect_reject("readonly");
        img_readonly = 1'b0;

        pulse_ram_wr();
        tick(1);
        check("dirty_set", {31'd0, dirty}, 32'd1);

        run_save(8'h02, -1, 5, 1'b0, "full16");
        check("word_0305", {16'd0, word_0305}, 32'h0000_1234);
        check("last_lba_wrapped", sd.sd_lba, 32'h0000_0007);

        run_save(8'h01, 2, -1, 1'b1, "wr_mid");

        // Host never acks: abort after 15 cycles of sd_wr.
        e0 = err_cnt;
        pulse_save();
        n = 0;
        for (int c = 0; c < 100 && !err; c++) begin
            if (sd.sd_wr) n++;
            @(negedge clk_sys);
        end
        check("timeout_wr_cycles", 32'(n), 32'd15);
        check("timeout_sd_wr", {31'd0, sd.sd_wr}, 32'd0);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_dirty", {31'd0, dirty}, 32'd1);
        tick(1);
        check("timeout_err_count", 32'(err_cnt - e0), 32'd1);
        $display("timeout: sd_wr high %0d cycles", n);

        // Reset in the middle of a transfer.
        d0 = done_cnt; e0 = err_cnt;
        pulse_save();
        n = 0;
        while (!sd.sd_wr && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        check("mid_sd_wr_seen", {31'd0, sd.sd_wr}, 32'd1);
        sd.sd_ack = 1'b1;
        tick(5);
        reset_n = 1'b0;
        tick(1);
        check("mid_rst_sd_wr", {31'd0, sd.sd_wr}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_dirty", {31'd0, dirty}, 32'd0);
        check("mid_rst_lba", sd.sd_lba, 32'd0);
        check("mid_rst_bram_addr", {16'd0, bram_addr}, 32'd0);
        reset_n = 1'b1;
        tick(4);
        check("late_ack_sd_wr", {31'd0, sd.sd_wr}, 32'd0);
        check("late_ack_busy", {31'd0, busy}, 32'd0);
        sd.sd_ack = 1'b0;
        tick(2);
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_rst_no_err", 32'(err_cnt - e0), 32'd0);
        $display("reset mid-transfer: outputs cleared");

        // OSD close with autosave enabled.
        img_mounted = 1'b1; tick(1); img_mounted = 1'b0;
        ram_size = 8'h01;
        autosave_on = 1'b1;
        pulse_ram_wr();
        osd_status = 1'b1;
        tick(2);
        d0 = done_cnt; n = wr_rises;
        osd_status = 1'b0;
`ifdef BK_AUTOSAVE_EN
        serve(model_nsec(8'h01), -1, -1);
        wait_done(d0);
        check("auto_wr_count", 32'(wr_rises - n), 32'd4);
        check("auto_dirty", {31'd0, dirty}, 32'd0);
        n = wr_rises;
        osd_status = 1'b1; tick(2); osd_status = 1'b0;
        tick(20);
        check("auto_clean_no_save", 32'(wr_rises - n), 32'd0);
`else
        tick(20);
        check("auto_disabled_no_save", 32'(wr_rises - n), 32'd0);
        check("auto_disabled_dirty", {31'd0, dirty}, 32'd1);
`endif
        check("auto_busy_idle", {31'd0, busy}, 32'd0);
        $display("autosave: requests=%0d", wr_rises - n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
